ascii_case_stream: RTL and testbench

// - Streaming, multi-lane successor to the single-byte combinational toUpper converter.
// - Accepts LANES ASCII bytes per beat over a valid/ready handshake.
// - Applies a per-beat case mode: pass, upper, lower or toggle.
// - Output is registered, behind a skid buffer; counts bytes whose value changed.
// - Sits between the UART/byte-stream front end and the text-processing datapath.

---
 rtl/ascii_case_pkg.sv | 25 ++
 rtl/ascii_case_stream_if.sv | 21 ++
 rtl/ascii_case_lane.sv | 33 +++
 rtl/ascii_case_stream.sv | 152 +++++++++++++++
 tb/tb_ascii_case_stream.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ascii_case_pkg.sv
// Shared constants for the streaming ASCII case converter.
// Mode encodings, letter bounds and the case bit.
package ascii_case_pkg;

  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_UPPER  = 2'b01;
  localparam logic [1:0] MODE_LOWER  = 2'b10;
  localparam logic [1:0] MODE_TOGGLE = 2'b11;

  localparam logic [7:0] UPPER_LO = 8'h41;
  localparam logic [7:0] UPPER_HI = 8'h5A;
  localparam logic [7:0] LOWER_LO = 8'h61;
  localparam logic [7:0] LOWER_HI = 8'h7A;

  localparam int CASE_BIT = 5;

  function automatic logic in_range(
    input logic [7:0] b,
    input logic [7:0] lo,
    input logic [7:0] hi
  );
    return (b >= lo) && (b <= hi);
  endfunction

endpackage

// File: rtl/ascii_case_stream_if.sv
// Valid/ready byte-beat bundle for the case converter.
// Mode rides with the beat so downstream sees what was applied.
interface ascii_case_stream_if #(
  parameter int LANES = 4
);
  logic                 valid;
  logic                 ready;
  logic [8*LANES-1:0]   data;
  logic [LANES-1:0]     keep;
  logic [1:0]           mode;

  modport master (
    output valid, data, keep, mode,
    input  ready
  );

  modport slave (
    input  valid, data, keep, mode,
    output ready
  );
endinterface

// File: rtl/ascii_case_lane.sv
// One byte lane of the case converter, purely combinational.
// Only the case bit can flip, and only for letters on kept lanes.
module ascii_case_lane
  import ascii_case_pkg::*;
(
  input  logic [7:0] byte_i,
  input  logic [1:0] mode_i,
  input  logic       keep_i,
  output logic [7:0] byte_o,
  output logic       changed_o
);

  logic is_up;
  logic is_lo;
  logic flip;

  always_comb begin
    is_up = in_range(byte_i, UPPER_LO, UPPER_HI);
    is_lo = in_range(byte_i, LOWER_LO, LOWER_HI);
    flip  = 1'b0;
    unique case (1'b1)
      (mode_i == MODE_UPPER):  flip = is_lo;
      (mode_i == MODE_LOWER):  flip = is_up;
      (mode_i == MODE_TOGGLE): flip = is_up | is_lo;
      default:                 flip = 1'b0;
    endcase
    flip = flip & keep_i;
    byte_o = byte_i;
    byte_o[CASE_BIT] = byte_i[CASE_BIT] ^ flip;
    changed_o = flip;
  end

endmodule

// File: rtl/ascii_case_stream.sv
// Multi-lane ASCII case converter with registered output,
// one-entry skid buffer and saturating converted-byte counter.
module ascii_case_stream
  import ascii_case_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  ascii_case_stream_if.slave  in_if,
  ascii_case_stream_if.master out_if,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] conv_cnt
);

  localparam int DATA_W = 8 * LANES;
  localparam int POP_W  = $clog2(LANES + 1);

  logic [DATA_W-1:0] conv_data;
  logic [LANES-1:0]  conv_chg;
  logic [POP_W-1:0]  conv_pop;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ascii_case_lane u_lane (
      .byte_i    (in_if.data[8*i +: 8]),
      .mode_i    (in_if.mode),
      .keep_i    (in_if.keep[i]),
      .byte_o    (conv_data[8*i +: 8]),
      .changed_o (conv_chg[i])
    );
  end

  always_comb begin
    conv_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      conv_pop = conv_pop + POP_W'(conv_chg[i]);
    end
  end

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [LANES-1:0]  out_keep_q,  out_keep_d;
  logic [1:0]        out_mode_q,  out_mode_d;
  logic [POP_W-1:0]  out_pop_q,   out_pop_d;

  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [LANES-1:0]  skid_keep_q,  skid_keep_d;
  logic [1:0]        skid_mode_q,  skid_mode_d;
  logic [POP_W-1:0]  skid_pop_q,   skid_pop_d;

  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              in_fire;
  logic              out_fire;
  logic              out_free;
  logic [CNT_W:0]    cnt_sum;

  always_comb begin
    in_fire  = in_if.valid & in_ready_q;
    out_fire = out_valid_q & out_if.ready;
    out_free = ~out_valid_q | out_if.ready;

    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_mode_d   = out_mode_q;
    out_pop_d    = out_pop_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_keep_d  = skid_keep_q;
    skid_mode_d  = skid_mode_q;
    skid_pop_d   = skid_pop_q;

    // in_ready is low whenever the skid is full,
    // so draining the skid never races a new beat.
    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_keep_d   = skid_keep_q;
        out_mode_d   = skid_mode_q;
        out_pop_d    = skid_pop_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_valid_d = 1'b1;
        out_data_d  = conv_data;
        out_keep_d  = in_if.keep;
        out_mode_d  = in_if.mode;
        out_pop_d   = conv_pop;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = conv_data;
      skid_keep_d  = in_if.keep;
      skid_mode_d  = in_if.mode;
      skid_pop_d   = conv_pop;
    end

    in_ready_d = ~skid_valid_d;

    cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(out_pop_q);
    cnt_d   = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_fire) begin
      cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_mode_q   <= MODE_PASS;
      out_pop_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_keep_q  <= '0;
      skid_mode_q  <= MODE_PASS;
      skid_pop_q   <= '0;
      in_ready_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_mode_q   <= out_mode_d;
      out_pop_q    <= out_pop_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_keep_q  <= skid_keep_d;
      skid_mode_q  <= skid_mode_d;
      skid_pop_q   <= skid_pop_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_if.ready  = in_ready_q;
  assign out_if.valid = out_valid_q;
  assign out_if.data  = out_data_q;
  assign out_if.keep  = out_keep_q;
  assign out_if.mode  = out_mode_q;
  assign conv_cnt     = cnt_q;

endmodule

// File: tb/tb_ascii_case_stream.sv
// Bench for ascii_case_stream: directed cases plus random
// streams checked against a queue-based byte-level model.
module tb_ascii_case_stream;

  localparam int LANES = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cnt_clr;
  logic [CNT_W-1:0] conv_cnt;

  ascii_case_stream_if #(.LANES(LANES)) in_if ();
  ascii_case_stream_if #(.LANES(LANES)) out_if ();

  ascii_case_stream #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_if    (in_if),
    .out_if   (out_if),
    .cnt_clr  (cnt_clr),
    .conv_cnt (conv_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic [2:0]  n;
  } exp_t;

  exp_t exp_q[$];
  int   model_cnt = 0;

  logic        f_in, f_out, f_ov, t_rdy;
  logic [31:0] o_d;
  logic [3:0]  o_k;
  exp_t        o_e;

  function automatic exp_t ref_beat(
    input logic [31:0] d,
    input logic [3:0]  k,
    input logic [1:0]  m
  );
    exp_t e;
    e.d = d;
    e.k = k;
    e.n = '0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b, r;
      b = d[8*i +: 8];
      r = b;
      if (k[i]) begin
        if ((m == 2'd1 || m == 2'd3) && b >= 8'h61 && b <= 8'h7A)
          r = b - 8'h20;
        else if ((m == 2'd2 || m == 2'd3) && b >= 8'h41 && b <= 8'h5A)
          r = b + 8'h20;
      end
      e.d[8*i +: 8] = r;
      if (r != b) e.n = e.n + 3'd1;
    end
    return e;
  endfunction

  function automatic logic [7:0] rbyte();
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    return 8'(8'h40 + $urandom_range(0, 63));
  endfunction

  function automatic logic [31:0] rword();
    return {rbyte(), rbyte(), rbyte(), rbyte()};
  endfunction

  // Drives one cycle, records handshakes and advances the model.
  task automatic tick(
    input logic        v,
    input logic [31:0] d,
    input logic [3:0]  k,
    input logic [1:0]  m,
    input logic        ordy,
    input logic        clr
  );
    in_if.valid  = v;
    in_if.data   = d;
    in_if.keep   = k;
    in_if.mode   = m;
    out_if.ready = ordy;
    cnt_clr      = clr;
    t_rdy        = ordy;
    #1;
    f_in  = v && in_if.ready;
    f_ov  = out_if.valid;
    f_out = out_if.valid && ordy;
    o_d   = out_if.data;
    o_k   = out_if.keep;
    o_e   = 'x;
    if (f_out && exp_q.size() > 0) o_e = exp_q.pop_front();
    if (f_in) exp_q.push_back(ref_beat(d, k, m));
    if (clr) model_cnt = 0;
    else if (f_out && !$isunknown(o_e))
      model_cnt = (model_cnt + int'(o_e.n) > CMAX) ? CMAX
                : model_cnt + int'(o_e.n);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    tick(1'b0, '0, '0, 2'd0, ordy, 1'b0);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_if.valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_if.valid); end
    checks++; if (out_if.data !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", out_if.data); end
    checks++; if (out_if.keep !== 4'h0) begin failures++; $display("FAIL rst_keep got=%h exp=0", out_if.keep); end
    checks++; if (conv_cnt !== 4'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", conv_cnt); end
    checks++; if (in_if.ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", in_if.ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (in_if.ready !== 1'b0) begin failures++; $display("FAIL rel_ready_early got=%b exp=0", in_if.ready); end
    @(posedge clk); #1;
    checks++; if (in_if.ready !== 1'b1) begin failures++; $display("FAIL rel_ready got=%b exp=1", in_if.ready); end
  endtask

  task automatic test_basic();
    tick(1'b1, 32'h7A615A41, 4'hF, 2'd1, 1'b1, 1'b0);
    checks++; if (f_in !== 1'b1) begin failures++; $display("FAIL basic_accept got=%b exp=1", f_in); end
    checks++; if (out_if.valid !== 1'b1 || out_if.data !== 32'h5A415A41) begin failures++; $display("FAIL basic_out got=%b/%h exp=1/5a415a41", out_if.valid, out_if.data); end
    checks++; if (conv_cnt !== 4'd0) begin failures++; $display("FAIL basic_cnt_early got=%0d exp=0", conv_cnt); end
    idle(1'b1);
    checks++; if (f_out !== 1'b1 || o_d !== o_e.d || o_k !== 4'hF) begin failures++; $display("FAIL basic_deliver got=%b/%h/%h exp=1/%h/f", f_out, o_d, o_k, o_e.d); end
    checks++; if (conv_cnt !== 4'd2) begin failures++; $display("FAIL basic_cnt got=%0d exp=2", conv_cnt); end
  endtask

  task automatic test_boundaries();
    logic [7:0]  bnd [6];
    logic [31:0] d;
    logic [3:0]  c0;
    bnd = '{8'h40, 8'h5B, 8'h60, 8'h7B, 8'hE1, 8'h00};
    c0 = conv_cnt;
    for (int m = 1; m < 4; m++) begin
      for (int j = 0; j < 2; j++) begin
        for (int l = 0; l < 4; l++) d[8*l +: 8] = bnd[(4*j + l) % 6];
        tick(1'b1, d, 4'hF, 2'(m), 1'b1, 1'b0);
        checks++; if (f_in !== 1'b1) begin failures++; $display("FAIL bnd_throughput got=%b exp=1", f_in); end
        if (f_out) begin
          checks++; if (o_d !== o_e.d) begin failures++; $display("FAIL bnd_data got=%h exp=%h", o_d, o_e.d); end
        end
      end
    end
    idle(1'b1);
    checks++; if (f_out !== 1'b1 || o_d !== o_e.d) begin failures++; $display("FAIL bnd_last got=%h exp=%h", o_d, o_e.d); end
    checks++; if (conv_cnt !== c0) begin failures++; $display("FAIL bnd_cnt got=%0d exp=%0d", conv_cnt, c0); end
  endtask

  task automatic test_toggle_keep();
    logic [3:0] c0;
    c0 = conv_cnt;
    tick(1'b1, 32'h61426142, 4'b0101, 2'd3, 1'b1, 1'b0);
    idle(1'b1);
    checks++; if (f_out !== 1'b1 || o_d !== 32'h61626162) begin failures++; $display("FAIL tgl_data got=%h exp=61626162", o_d); end
    checks++; if (o_k !== 4'b0101) begin failures++; $display("FAIL tgl_keep got=%b exp=0101", o_k); end
    checks++; if (conv_cnt !== 4'(c0 + 4'd2)) begin failures++; $display("FAIL tgl_cnt got=%0d exp=%0d", conv_cnt, c0 + 2); end
  endtask

  task automatic test_backpressure();
    logic [31:0] bd [8];
    logic [3:0]  bk [8];
    logic [1:0]  bm [8];
    int sent, rcvd, cyc;
    logic ordy;
    for (int i = 0; i < 8; i++) begin
      bd[i] = rword();
      bk[i] = 4'($urandom);
      bm[i] = 2'($urandom);
    end
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    while (rcvd < 8 && cyc < 200) begin
      ordy = (cyc < 5) ? 1'b0 : 1'($urandom_range(0, 1));
      if (sent < 8) tick(1'b1, bd[sent], bk[sent], bm[sent], ordy, 1'b0);
      else idle(ordy);
      if (f_in) sent++;
      if (f_in && sent == 2 && cyc < 5) begin
        checks++; if (in_if.ready !== 1'b0) begin failures++; $display("FAIL bp_ready_drop got=%b exp=0", in_if.ready); end
      end
      if (f_ov && !t_rdy) begin
        checks++; if (out_if.valid !== 1'b1 || out_if.data !== o_d) begin failures++; $display("FAIL bp_hold got=%b/%h exp=1/%h", out_if.valid, out_if.data, o_d); end
      end
      if (f_out) begin
        rcvd++;
        checks++; if (o_d !== o_e.d || o_k !== o_e.k) begin failures++; $display("FAIL bp_beat got=%h/%h exp=%h/%h", o_d, o_k, o_e.d, o_e.k); end
      end
      checks++; if (conv_cnt !== 4'(model_cnt)) begin failures++; $display("FAIL bp_cnt got=%0d exp=%0d", conv_cnt, model_cnt); end
      cyc++;
    end
    checks++; if (rcvd != 8 || exp_q.size() != 0) begin failures++; $display("FAIL bp_count got=%0d left=%0d exp=8/0", rcvd, exp_q.size()); end
  endtask

  task automatic test_random_stream();
    for (int c = 0; c < 120; c++) begin
      tick(1'($urandom_range(0, 3) != 0), rword(), 4'($urandom), 2'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
      if (f_ov && !t_rdy) begin
        checks++; if (out_if.valid !== 1'b1 || out_if.data !== o_d) begin failures++; $display("FAIL rnd_hold got=%b/%h exp=1/%h", out_if.valid, out_if.data, o_d); end
      end
      if (f_out) begin
        checks++; if (o_d !== o_e.d || o_k !== o_e.k) begin failures++; $display("FAIL rnd_beat got=%h/%h exp=%h/%h", o_d, o_k, o_e.d, o_e.k); end
      end
      checks++; if (conv_cnt !== 4'(model_cnt)) begin failures++; $display("FAIL rnd_cnt got=%0d exp=%0d", conv_cnt, model_cnt); end
    end
    for (int c = 0; c < 10 && (exp_q.size() != 0 || out_if.valid); c++) begin
      idle(1'b1);
      if (f_out) begin
        checks++; if (o_d !== o_e.d || o_k !== o_e.k) begin failures++; $display("FAIL rnd_drain got=%h/%h exp=%h/%h", o_d, o_k, o_e.d, o_e.k); end
      end
    end
    checks++; if (exp_q.size() != 0 || out_if.valid !== 1'b0) begin failures++; $display("FAIL rnd_empty got=%0d/%b exp=0/0", exp_q.size(), out_if.valid); end
  endtask

  task automatic test_counter_sat();
    idle(1'b1);
    tick(1'b0, '0, '0, 2'd0, 1'b1, 1'b1);
    checks++; if (conv_cnt !== 4'd0) begin failures++; $display("FAIL sat_clr got=%0d exp=0", conv_cnt); end
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 32'h61616161, 4'hF, 2'd1, 1'b1, 1'b0);
      checks++; if (conv_cnt !== 4'(model_cnt)) begin failures++; $display("FAIL sat_step got=%0d exp=%0d", conv_cnt, model_cnt); end
    end
    idle(1'b1);
    checks++; if (conv_cnt !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", conv_cnt); end
    tick(1'b1, 32'h61616161, 4'hF, 2'd1, 1'b1, 1'b0);
    tick(1'b0, '0, '0, 2'd0, 1'b1, 1'b1);
    checks++; if (f_out !== 1'b1 || conv_cnt !== 4'd0) begin failures++; $display("FAIL sat_clr_fire got=%b/%0d exp=1/0", f_out, conv_cnt); end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 32'h61616161, 4'hF, 2'd1, 1'b1, 1'b0);
    idle(1'b1);
    tick(1'b1, rword(), 4'hF, 2'd1, 1'b0, 1'b0);
    tick(1'b1, rword(), 4'hF, 2'd2, 1'b0, 1'b0);
    checks++; if (in_if.ready !== 1'b0 || out_if.valid !== 1'b1) begin failures++; $display("FAIL mid_full got=%b/%b exp=0/1", in_if.ready, out_if.valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_if.valid !== 1'b0 || conv_cnt !== 4'd0) begin failures++; $display("FAIL mid_rst got=%b/%0d exp=0/0", out_if.valid, conv_cnt); end
    exp_q.delete();
    model_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1'b0);
    tick(1'b1, 32'h41424344, 4'hF, 2'd2, 1'b0, 1'b0);
    checks++; if (f_in !== 1'b1 || out_if.data !== 32'h61626364) begin failures++; $display("FAIL mid_next got=%b/%h exp=1/61626364", f_in, out_if.data); end
    idle(1'b1);
    checks++; if (f_out !== 1'b1 || o_d !== o_e.d || conv_cnt !== 4'd4) begin failures++; $display("FAIL mid_deliver got=%h/%0d exp=%h/4", o_d, conv_cnt, o_e.d); end
    idle(1'b1);
    checks++; if (out_if.valid !== 1'b0) begin failures++; $display("FAIL mid_stale got=%b exp=0", out_if.valid); end
  endtask

  initial begin
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    in_if.keep   = '0;
    in_if.mode   = 2'd0;
    out_if.ready = 1'b0;
    cnt_clr      = 1'b0;
    test_reset();
    test_basic();
    test_boundaries();
    test_toggle_keep();
    test_backpressure();
    test_random_stream();
    test_counter_sat();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
